// File: rtl/noc_credit_tx.sv
// Credit-based NoC flit transmitter: one-cycle launch register, downstream credit counter and a packet FSM.
// Optional macro TX_PKT_CNT_EN adds an 8-bit wrapping count of transmitted packet tails on pkt_count.
module noc_credit_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  input  logic                  src_last,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic                  link_write,
  output logic                  link_last,
  input  logic                  credit_return,
  output logic [3:0]            credits_avail,
  output logic                  in_packet,
  output logic                  credit_err
`ifdef TX_PKT_CNT_EN
  ,
  output logic [7:0]            pkt_count
`endif
);

  localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] credit_cnt;
  logic       xfer;

  // Gating with rst keeps the source from seeing a handshake that reset will discard.
  assign src_ready     = rst & en & (credit_cnt != 4'd0);
  assign xfer          = src_valid & src_ready;
  assign credits_avail = credit_cnt;
  assign in_packet     = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (xfer && !src_last) state_next = ACTIVE;
      ACTIVE: if (xfer && src_last)  state_next = IDLE;
    endcase
  end

  // A return arriving with a full counter means the downstream returned more than it was given.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else if (xfer && !credit_return) begin
      credit_cnt <= credit_cnt - 4'd1;
    end else if (!xfer && credit_return) begin
      if (credit_cnt == CREDIT_MAX) credit_err <= 1'b1;
      else                          credit_cnt <= credit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      link_write <= 1'b0;
      link_data  <= '0;
      link_last  <= 1'b0;
    end else begin
      link_write <= xfer;
      if (xfer) begin
        link_data <= src_data;
        link_last <= src_last;
      end
    end
  end

`ifdef TX_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                  pkt_count <= 8'd0;
    else if (xfer && src_last) pkt_count <= pkt_count + 8'd1;
  end
`endif

endmodule
